// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a word-addressed internal RAM with independent INCR read and write paths.
// Writes honour byte strobes; reads return one registered beat per cycle.
module axi_mem_slave #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]              S_AXI_AWLEN,
   input  logic [2:0]              S_AXI_AWSIZE,
   input  logic [1:0]              S_AXI_AWBURST,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                    S_AXI_WLAST,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   output logic [ID_WIDTH-1:0]     S_AXI_BID,
   output logic [1:0]              S_AXI_BRESP,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]              S_AXI_ARLEN,
   input  logic [2:0]              S_AXI_ARSIZE,
   input  logic [1:0]              S_AXI_ARBURST,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   output logic [ID_WIDTH-1:0]     S_AXI_RID,
   output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic                    S_AXI_RLAST,
   output logic [1:0]              S_AXI_RRESP
);
   localparam int ADDRLSB = $clog2(DATA_WIDTH) - 3;
   localparam int WAW     = ADDR_WIDTH - ADDRLSB;
   localparam int DEPTH   = 1 << WAW;
   localparam int NB      = DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   wstate_t               wstate_q, wstate_d;
   logic [ID_WIDTH-1:0]   wid_q, wid_d;
   logic [WAW-1:0]        waddr_q, waddr_d;
   logic [8:0]            wcnt_q, wcnt_d;
   logic                  werr_q, werr_d;
   logic                  mem_we;

   rstate_t               rstate_q, rstate_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   logic [WAW-1:0]        raddr_q, raddr_d;
   logic [8:0]            rcnt_q, rcnt_d;
   logic                  rerr_q, rerr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rlast_q, rlast_d;

   // Write path
   always_comb begin
      wstate_d = wstate_q;
      wid_d    = wid_q;
      waddr_d  = waddr_q;
      wcnt_d   = wcnt_q;
      werr_d   = werr_q;
      mem_we   = 1'b0;
      case (wstate_q)
         W_IDLE: if (S_AXI_AWVALID) begin
            wid_d    = S_AXI_AWID;
            waddr_d  = S_AXI_AWADDR[ADDR_WIDTH-1:ADDRLSB];
            wcnt_d   = {1'b0, S_AXI_AWLEN} + 9'd1;
            werr_d   = (S_AXI_AWBURST != 2'b01) || (S_AXI_AWSIZE != 3'(ADDRLSB));
            wstate_d = W_DATA;
         end
         W_DATA: if (S_AXI_WVALID) begin
            mem_we  = !werr_q;
            waddr_d = waddr_q + WAW'(1);
            wcnt_d  = wcnt_q - 9'd1;
            // WLAST must coincide exactly with the final counted beat
            if (S_AXI_WLAST != (wcnt_q == 9'd1)) werr_d = 1'b1;
            if (wcnt_q == 9'd1) wstate_d = W_RESP;
         end
         W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wstate_q <= W_IDLE;
         wid_q    <= '0;
         waddr_q  <= '0;
         wcnt_q   <= '0;
         werr_q   <= 1'b0;
      end else begin
         wstate_q <= wstate_d;
         wid_q    <= wid_d;
         waddr_q  <= waddr_d;
         wcnt_q   <= wcnt_d;
         werr_q   <= werr_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (mem_we)
         for (int i = 0; i < NB; i++)
            if (S_AXI_WSTRB[i]) mem[waddr_q][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
   end

   assign S_AXI_AWREADY = (wstate_q == W_IDLE);
   assign S_AXI_WREADY  = (wstate_q == W_DATA);
   assign S_AXI_BVALID  = (wstate_q == W_RESP);
   assign S_AXI_BID     = wid_q;
   assign S_AXI_BRESP   = {werr_q, 1'b0};

   // Read path: RDATA is a register loaded from mem, so a same-edge write is not seen
   always_comb begin
      rstate_d = rstate_q;
      rid_d    = rid_q;
      raddr_d  = raddr_q;
      rcnt_d   = rcnt_q;
      rerr_d   = rerr_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      rlast_d  = rlast_q;
      case (rstate_q)
         R_IDLE: if (S_AXI_ARVALID) begin
            rid_d    = S_AXI_ARID;
            raddr_d  = S_AXI_ARADDR[ADDR_WIDTH-1:ADDRLSB];
            rcnt_d   = {1'b0, S_AXI_ARLEN} + 9'd1;
            rerr_d   = (S_AXI_ARBURST != 2'b01) || (S_AXI_ARSIZE != 3'(ADDRLSB));
            rdata_d  = mem[S_AXI_ARADDR[ADDR_WIDTH-1:ADDRLSB]];
            rvalid_d = 1'b1;
            rlast_d  = (S_AXI_ARLEN == 8'd0);
            rstate_d = R_DATA;
         end
         R_DATA: if (S_AXI_RREADY) begin
            if (rlast_q) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               rstate_d = R_IDLE;
            end else begin
               raddr_d = raddr_q + WAW'(1);
               rdata_d = mem[raddr_q + WAW'(1)];
               rlast_d = (rcnt_q == 9'd2);
               rcnt_d  = rcnt_q - 9'd1;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rstate_q <= R_IDLE;
         rid_q    <= '0;
         raddr_q  <= '0;
         rcnt_q   <= '0;
         rerr_q   <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
      end else begin
         rstate_q <= rstate_d;
         rid_q    <= rid_d;
         raddr_q  <= raddr_d;
         rcnt_q   <= rcnt_d;
         rerr_q   <= rerr_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
      end
   end

   assign S_AXI_ARREADY = (rstate_q == R_IDLE);
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RID     = rid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RLAST   = rlast_q;
   assign S_AXI_RRESP   = {rerr_q, 1'b0};
endmodule
